cmp_share_arb: RTL and testbench

CMP_SHARE_ARB -- requirements
Module: cmp_share_arb

---
 rtl/cmp_share_arb.sv | 164 ++++++++++++++++
 tb/tb_cmp_share_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_share_arb.sv
// cmp_share_arb
// Shares one unsigned three-output magnitude comparator among N_REQ
// requesters. Requesters are picked round-robin in IDLE. The winner's
// operands are latched and compared in CMP. The result is then held in RESP
// until the consumer takes it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | sample req, pick winner, latch operands, pulse gnt next
// CMP   | one cycle: compare latched operands, register result + id
// RESP  | rsp_valid high, hold result until rsp_ready
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   req        per-requester request, bit i = requester i
//   a_in/b_in  packed operands, requester i at [WIDTH*i +: WIDTH]
//   gnt        one-hot single-cycle grant (operands of that requester latched)
//   rsp_valid  result available (state RESP)
//   rsp_ready  consumer accepts result
//   rsp_id     requester index of the current result
//   rsp_eq/ls/gt  A == B, A < B, A > B (unsigned)
//   busy       high whenever not IDLE
//   cmp_count  completed handshakes, saturating at 255
module cmp_share_arb #(
    parameter int WIDTH = 4,
    parameter int N_REQ = 4   // must be a power of two so the pointer wraps naturally
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   a_in,
    input  logic [N_REQ*WIDTH-1:0]   b_in,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     rsp_eq,
    output logic                     rsp_ls,
    output logic                     rsp_gt,
    output logic                     busy,
    output logic [7:0]               cmp_count
);

    localparam int IDW = $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [IDW-1:0]   ptr_q,    ptr_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [IDW-1:0]   id_q,     id_d;
    logic [N_REQ-1:0] gnt_q,    gnt_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             eq_q,     eq_d;
    logic             ls_q,     ls_d;
    logic             gt_q,     gt_d;
    logic [7:0]       cnt_q,    cnt_d;

    logic             found;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   idx;

    // Round-robin search: first requester at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr_q + IDW'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        gnt_d    = '0;
        rsp_id_d = rsp_id_q;
        eq_d     = eq_q;
        ls_d     = ls_q;
        gt_d     = gt_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    a_d        = a_in[int'(win)*WIDTH +: WIDTH];
                    b_d        = b_in[int'(win)*WIDTH +: WIDTH];
                    id_d       = win;
                    gnt_d[win] = 1'b1;
                    ptr_d      = win + IDW'(1);
                    state_d    = ST_CMP;
                end
            end
            ST_CMP: begin
                // The single shared comparator only ever sees the latched operands.
                rsp_id_d = id_q;
                eq_d     = (a_q == b_q);
                ls_d     = (a_q <  b_q);
                gt_d     = (a_q >  b_q);
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            gnt_q    <= '0;
            rsp_id_q <= '0;
            eq_q     <= 1'b0;
            ls_q     <= 1'b0;
            gt_q     <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            gnt_q    <= gnt_d;
            rsp_id_q <= rsp_id_d;
            eq_q     <= eq_d;
            ls_q     <= ls_d;
            gt_q     <= gt_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_eq    = eq_q;
    assign rsp_ls    = ls_q;
    assign rsp_gt    = gt_q;
    assign cmp_count = cnt_q;

endmodule

// File: tb/tb_cmp_share_arb.sv
// Bench for cmp_share_arb: directed stimulus pushes expected grants and
// results into queues; monitors pop and compare whenever the DUT presents
// a grant or a result handshake.
module tb_cmp_share_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        rsp_ready = 1'b0;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_eq, rsp_ls, rsp_gt;
    logic        busy;
    logic [7:0]  cmp_count;

    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] LS = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_gnt_q[$];
    logic [4:0] exp_rsp_q[$];   // {id, eq, ls, gt}

    cmp_share_arb #(.WIDTH(4), .N_REQ(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_eq    (rsp_eq),
        .rsp_ls    (rsp_ls),
        .rsp_gt    (rsp_gt),
        .busy      (busy),
        .cmp_count (cmp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] id, input logic [2:0] code);
        exp_gnt_q.push_back(g);
        exp_rsp_q.push_back({id, code});
    endtask

    // Grant monitor: not gated by reset so a grant pulse that precedes a reset is still seen.
    always @(negedge clk) begin
        if (gnt != 4'b0) begin
            chk("gnt_onehot", $countones(gnt), 1);
            if (exp_gnt_q.size() == 0) chk("gnt_unexpected", {28'b0, gnt}, 0);
            else                       chk("gnt_order", {28'b0, gnt}, {28'b0, exp_gnt_q.pop_front()});
        end
    end

    // Result monitor: compares on each cycle that will complete a handshake.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            chk("rsp_onehot", $countones({rsp_eq, rsp_ls, rsp_gt}), 1);
            if (rsp_ready) begin
                if (exp_rsp_q.size() == 0)
                    chk("rsp_unexpected", {27'b0, rsp_id, rsp_eq, rsp_ls, rsp_gt}, 0);
                else
                    chk("rsp_fields", {27'b0, rsp_id, rsp_eq, rsp_ls, rsp_gt},
                        {27'b0, exp_rsp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] codes [4];
        codes[0] = LS; codes[1] = EQ; codes[2] = GT; codes[3] = EQ;

        // Reset state
        cyc(); cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_gnt",   {28'b0, gnt}, 0);
        chk("rst_valid", {31'b0, rsp_valid}, 0);
        chk("rst_busy",  {31'b0, busy}, 0);
        chk("rst_count", {24'b0, cmp_count}, 0);
        chk("rst_fields", {27'b0, rsp_id, rsp_eq, rsp_ls, rsp_gt}, 0);

        // Single request, latency T -> T+1 gnt -> T+2 valid
        cyc();
        req = 4'b0100; a_in = 16'h0900; b_in = 16'h0400; rsp_ready = 1'b1;
        push(4'b0100, 2'd2, GT);
        @(negedge clk);
        chk("t1_gnt_T0", {28'b0, gnt}, 0);
        chk("t1_busy_T0", {31'b0, busy}, 0);
        cyc(); @(negedge clk);
        chk("t1_gnt_T1", {28'b0, gnt}, 32'h4);
        chk("t1_busy_T1", {31'b0, busy}, 1);
        chk("t1_valid_T1", {31'b0, rsp_valid}, 0);
        req = 4'b0000;
        cyc(); @(negedge clk);
        chk("t1_valid_T2", {31'b0, rsp_valid}, 1);
        chk("t1_gnt_T2", {28'b0, gnt}, 0);
        cyc(); @(negedge clk);
        chk("t1_count", {24'b0, cmp_count}, 1);
        chk("t1_busy_T3", {31'b0, busy}, 0);

        // Round-robin from ptr 0, all equal operands
        reset = 1'b1; cyc(); reset = 1'b0;
        req = 4'b1111; a_in = 16'h5555; b_in = 16'h5555;
        push(4'b0001, 2'd0, EQ);
        push(4'b0010, 2'd1, EQ);
        push(4'b0100, 2'd2, EQ);
        push(4'b1000, 2'd3, EQ);
        push(4'b0001, 2'd0, EQ);
        repeat (13) cyc();
        req = 4'b0000;
        repeat (4) cyc();
        @(negedge clk);
        chk("rr_count", {24'b0, cmp_count}, 5);
        chk("rr_gnt_drained", exp_gnt_q.size(), 0);

        // Wrap 3 -> 0, boundary operands (req3: 15 vs 0, req0: 0 vs 15)
        req = 4'b1000; a_in = 16'hF000; b_in = 16'h000F;
        push(4'b1000, 2'd3, GT);
        push(4'b0001, 2'd0, LS);
        push(4'b1000, 2'd3, GT);
        cyc();
        req = 4'b1001;
        repeat (6) cyc();
        req = 4'b0000;
        repeat (4) cyc();
        @(negedge clk);
        chk("wrap_count", {24'b0, cmp_count}, 8);
        chk("wrap_rsp_drained", exp_rsp_q.size(), 0);

        // Backpressure: 5 cycles of rsp_ready low in RESP
        req = 4'b0010; a_in = 16'h0030; b_in = 16'h0070; rsp_ready = 1'b0;
        push(4'b0010, 2'd1, LS);
        cyc();
        req = 4'b0000;
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'b0, rsp_valid}, 1);
            chk("bp_fields", {27'b0, rsp_id, rsp_eq, rsp_ls, rsp_gt}, {27'b0, 2'd1, LS});
            chk("bp_gnt", {28'b0, gnt}, 0);
            chk("bp_busy", {31'b0, busy}, 1);
            cyc();
        end
        rsp_ready = 1'b1;
        cyc(); @(negedge clk);
        chk("bp_idle_valid", {31'b0, rsp_valid}, 0);
        chk("bp_idle_busy", {31'b0, busy}, 0);
        chk("bp_retain", {27'b0, rsp_id, rsp_eq, rsp_ls, rsp_gt}, {27'b0, 2'd1, LS});
        chk("bp_count", {24'b0, cmp_count}, 9);

        // Reset while in CMP discards the transaction
        req = 4'b0001; a_in = 16'h0001; b_in = 16'h0002;
        exp_gnt_q.push_back(4'b0001);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0; req = 4'b0000;
        @(negedge clk);
        chk("rcmp_zero", {16'b0, gnt, rsp_valid, busy, rsp_id, rsp_eq, rsp_ls, rsp_gt, cmp_count}, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(); @(negedge clk);
            chk("rcmp_no_valid", {31'b0, rsp_valid}, 0);
        end

        // Saturation: 256 handshakes from count 0
        req = 4'b1111; a_in = 16'h2E80; b_in = 16'h2181; rsp_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            push(4'(1 << (k % 4)), 2'(k % 4), codes[k % 4]);
        end
        repeat (766) cyc();
        req = 4'b0000;
        repeat (4) cyc();
        @(negedge clk);
        chk("sat_count", {24'b0, cmp_count}, 255);
        chk("sat_gnt_drained", exp_gnt_q.size(), 0);
        chk("sat_rsp_drained", exp_rsp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
